// File: rtl/tone_generator_pkg.sv
// Shared encodings for the multi-channel tone generator: waveform modes,
// control FSM states and the fixed-point gain shift.
package tone_generator_pkg;

  typedef enum logic [1:0] {
    MODE_SINE    = 2'b00,
    MODE_SQUARE  = 2'b01,
    MODE_SAW     = 2'b10,
    MODE_SILENCE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_CALC  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam int GAIN_W     = 8;
  localparam int GAIN_SHIFT = 8;

endpackage

// File: rtl/tone_generator_if.sv
// Frame output stream of the tone generator. A frame moves on a cycle where
// out_valid && out_ready; the source keeps out_valid/out_data stable until then.
interface tone_generator_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 24
);
  logic [CHANNELS*SAMPLE_W-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/tone_sine_lut.sv
// Quarter-wave sine ROM with 2^LUT_ADDR_W+1 entries built at elaboration,
// entry k = round(P*sin(pi/2*k/2^LUT_ADDR_W)); one-cycle registered read.
module tone_sine_lut #(
  parameter int LUT_ADDR_W = 8,
  parameter int SAMPLE_W   = 24
) (
  input  logic                  clk,
  input  logic [LUT_ADDR_W:0]   addr,
  output logic [SAMPLE_W-1:0]   data
);

  localparam int  DEPTH = (1 << LUT_ADDR_W) + 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = (2.0 ** (SAMPLE_W - 1)) - 1.0;

  function automatic logic [SAMPLE_W-1:0] entry(input int k);
    real x;
    x = PEAK * $sin((PI / 2.0) * real'(k) / real'(1 << LUT_ADDR_W));
    return SAMPLE_W'(longint'(x));
  endfunction

  logic [SAMPLE_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = entry(k);
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/tone_generator.sv
// Multi-channel tone source: per-channel phase accumulators, one shared sine
// table and gain stage, one frame per handshake. Optional gain: TONE_GENERATOR_GAIN_EN.
module tone_generator
  import tone_generator_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 24,
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS*PHASE_W-1:0] freq_word,
  input  logic [CHANNELS*2-1:0]       mode,
  input  logic [CHANNELS*GAIN_W-1:0]  gain,
  tone_generator_if.master            bus,
  output state_t                      dbg_state
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SAMPLE_W-1:0] PEAK = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MINV = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [LUT_ADDR_W:0] QUARTER = {1'b1, {LUT_ADDR_W{1'b0}}};

  state_t                       state;
  logic [CH_W-1:0]              ch;
  logic                         drain_cnt;
  logic                         valid_q;
  logic [PHASE_W-1:0]           phase [CHANNELS];
  logic [CHANNELS*SAMPLE_W-1:0] data_q;

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign dbg_state     = state;

  // Control: issue each channel once, let the pipeline empty, then hold the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CALC;
      ch        <= '0;
      drain_cnt <= 1'b0;
      valid_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) phase[c] <= '0;
    end else begin
      case (state)
        ST_CALC: begin
          if (ch == CH_W'(CHANNELS - 1)) begin
            ch        <= '0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            valid_q   <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= ST_CALC;
            for (int c = 0; c < CHANNELS; c++)
              phase[c] <= phase[c] + freq_word[c*PHASE_W +: PHASE_W];
          end
        end
        default: state <= ST_CALC;
      endcase
    end
  end

  // Issue: pick this channel's controls and derive table index / non-sine value.
  logic [PHASE_W-1:0]    iss_phase;
  mode_t                 iss_mode;
  logic [GAIN_W-1:0]     iss_gain;
  logic [1:0]            iss_quad;
  logic [LUT_ADDR_W-1:0] iss_a;
  logic [LUT_ADDR_W:0]   lut_idx;
  logic [SAMPLE_W-1:0]   saw_top;
  logic [SAMPLE_W-1:0]   iss_alt;

  assign iss_phase = phase[ch];
  assign iss_mode  = mode_t'(mode[32'(ch)*2 +: 2]);
  assign iss_gain  = gain[32'(ch)*GAIN_W +: GAIN_W];
  assign iss_quad  = iss_phase[PHASE_W-1 -: 2];
  assign iss_a     = iss_phase[PHASE_W-3 -: LUT_ADDR_W];
  assign lut_idx   = iss_quad[0] ? (QUARTER - {1'b0, iss_a}) : {1'b0, iss_a};

  if (PHASE_W >= SAMPLE_W) begin : g_saw_slice
    assign saw_top = iss_phase[PHASE_W-1 -: SAMPLE_W];
  end else begin : g_saw_pad
    assign saw_top = {iss_phase, {(SAMPLE_W-PHASE_W){1'b0}}};
  end

  always_comb begin
    iss_alt = '0;
    case (iss_mode)
      MODE_SQUARE: iss_alt = iss_phase[PHASE_W-1] ? MINV : PEAK;
      MODE_SAW:    iss_alt = {~saw_top[SAMPLE_W-1], saw_top[SAMPLE_W-2:0]};
      default:     iss_alt = '0;
    endcase
  end

  logic [SAMPLE_W-1:0] lut_data;

  tone_sine_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .SAMPLE_W   (SAMPLE_W)
  ) u_lut (
    .clk  (clk),
    .addr (lut_idx),
    .data (lut_data)
  );

  // Pipeline side-band registers alongside the table read, then S1 and S2.
  logic                p0_vld, p1_vld;
  logic [CH_W-1:0]     p0_ch, p1_ch;
  logic                p0_sine, p0_neg;
  logic [SAMPLE_W-1:0] p0_alt;
  logic [GAIN_W-1:0]   p0_gain, p1_gain;
  logic [SAMPLE_W-1:0] s1_sample, p1_sample;
  logic [SAMPLE_W-1:0] s2_value;

  assign s1_sample = p0_sine ? (p0_neg ? -lut_data : lut_data) : p0_alt;

`ifdef TONE_GENERATOR_GAIN_EN
  logic signed [SAMPLE_W+GAIN_W:0] prod;
  logic                            unused_prod;
  assign prod = (SAMPLE_W+GAIN_W+1)'($signed(p1_sample))
              * (SAMPLE_W+GAIN_W+1)'($signed({1'b0, p1_gain}));
  // Slicing above the shift is the floor-rounding arithmetic shift.
  assign s2_value    = prod[SAMPLE_W-1+GAIN_SHIFT : GAIN_SHIFT];
  assign unused_prod = ^{prod[SAMPLE_W+GAIN_W], prod[GAIN_SHIFT-1:0]};
`else
  logic unused_gain;
  assign s2_value    = p1_sample;
  assign unused_gain = ^p1_gain;
`endif

  always_ff @(posedge clk) begin
    p0_ch     <= ch;
    p0_sine   <= (iss_mode == MODE_SINE);
    p0_neg    <= iss_quad[1];
    p0_alt    <= iss_alt;
    p0_gain   <= iss_gain;
    p1_ch     <= p0_ch;
    p1_sample <= s1_sample;
    p1_gain   <= p0_gain;
    if (reset) begin
      p0_vld <= 1'b0;
      p1_vld <= 1'b0;
      data_q <= '0;
    end else begin
      p0_vld <= (state == ST_CALC);
      p1_vld <= p0_vld;
      if (p1_vld) data_q[32'(p1_ch)*SAMPLE_W +: SAMPLE_W] <= s2_value;
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator with hand-computed frame sequences;
// gain expectations follow TONE_GENERATOR_GAIN_EN.
module tb_tone_generator;
  import tone_generator_pkg::*;

  localparam int CH = 2;
  localparam int SW = 24;
  localparam int PW = 24;
  localparam int LA = 8;
  localparam int P  = 8388607;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CH*PW-1:0] freq_word;
  logic [CH*2-1:0]  mode;
  logic [CH*8-1:0]  gain;
  state_t           dbg_state;

  int errors = 0;
  int checks = 0;

  tone_generator_if #(.CHANNELS(CH), .SAMPLE_W(SW)) bus ();

  tone_generator #(
    .CHANNELS(CH), .SAMPLE_W(SW), .PHASE_W(PW), .LUT_ADDR_W(LA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freq_word (freq_word),
    .mode      (mode),
    .gain      (gain),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int ch_val(input logic [CH*SW-1:0] d, input int c);
    return int'($signed(d[c*SW +: SW]));
  endfunction

  task automatic setup(input logic [1:0] m0, input logic [1:0] m1,
                       input logic [23:0] f0, input logic [23:0] f1,
                       input logic [7:0] g0, input logic [7:0] g1);
    mode      = {m1, m0};
    freq_word = {f1, f0};
    gain      = {g1, g0};
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts negedges from the call.
  task automatic get_frame(output logic [CH*SW-1:0] d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 60);
    d = bus.out_data;
  endtask

  task automatic test_reset;
    setup(MODE_SINE, MODE_SILENCE, 24'h400000, 24'h0, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_data got=%h want=0", bus.out_data);
    end
    checks++;
    if (dbg_state !== ST_CALC) begin
      errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_CALC);
    end
    reset = 1'b0;
  endtask

  task automatic test_sine;
    int exp0 [5];
    logic [CH*SW-1:0] d;
    int lat;
    exp0 = '{0, P, 0, -P, 0};
    setup(MODE_SINE, MODE_SILENCE, 24'h400000, 24'h0, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      get_frame(d, lat);
      checks++;
      if (lat !== ((i == 0) ? CH + 2 : CH + 3)) begin
        errors++; $display("FAIL sine_latency[%0d] got=%0d want=%0d", i, lat, (i == 0) ? CH + 2 : CH + 3);
      end
      checks++;
      if (ch_val(d, 0) !== exp0[i]) begin
        errors++; $display("FAIL sine_ch0[%0d] got=%0d want=%0d", i, ch_val(d, 0), exp0[i]);
      end
      checks++;
      if (ch_val(d, 1) !== 0) begin
        errors++; $display("FAIL sine_ch1_silent[%0d] got=%0d want=0", i, ch_val(d, 1));
      end
    end
  endtask

  task automatic test_square_saw;
    int exp0 [4];
    int exp1 [4];
    logic [CH*SW-1:0] d;
    int lat;
    exp0 = '{P, P, -P - 1, -P - 1};
    exp1 = '{-8388608, -4194304, 0, 4194304};
    setup(MODE_SQUARE, MODE_SAW, 24'h400000, 24'h400000, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      get_frame(d, lat);
      checks++;
      if (ch_val(d, 0) !== exp0[i]) begin
        errors++; $display("FAIL square_ch0[%0d] got=%0d want=%0d", i, ch_val(d, 0), exp0[i]);
      end
      checks++;
      if (ch_val(d, 1) !== exp1[i]) begin
        errors++; $display("FAIL saw_ch1[%0d] got=%0d want=%0d", i, ch_val(d, 1), exp1[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [CH*SW-1:0] d;
    int lat;
    setup(MODE_SINE, MODE_SAW, 24'h400000, 24'h400000, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    do_reset;
    get_frame(d, lat);
    get_frame(d, lat);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mode = {MODE_SILENCE, MODE_SILENCE};
      checks++;
      if (bus.out_valid !== 1'b1 || ch_val(bus.out_data, 0) !== P ||
          ch_val(bus.out_data, 1) !== -4194304) begin
        errors++;
        $display("FAIL hold[%0d] valid=%b ch0=%0d ch1=%0d want valid=1 ch0=%0d ch1=%0d",
                 i, bus.out_valid, ch_val(bus.out_data, 0), ch_val(bus.out_data, 1), P, -4194304);
      end
    end
    mode = {MODE_SAW, MODE_SINE};
    bus.out_ready = 1'b1;
    get_frame(d, lat);
    checks++;
    if (lat !== CH + 3 || ch_val(d, 0) !== 0 || ch_val(d, 1) !== 0) begin
      errors++; $display("FAIL after_hold lat=%0d ch0=%0d ch1=%0d want lat=%0d ch0=0 ch1=0",
                         lat, ch_val(d, 0), ch_val(d, 1), CH + 3);
    end
    get_frame(d, lat);
    checks++;
    if (ch_val(d, 0) !== -P || ch_val(d, 1) !== 4194304) begin
      errors++; $display("FAIL after_hold_next ch0=%0d ch1=%0d want ch0=%0d ch1=4194304",
                         ch_val(d, 0), ch_val(d, 1), -P);
    end
  endtask

  task automatic test_wrap;
    int exp0 [5];
    logic [CH*SW-1:0] d;
    int lat;
    exp0 = '{-8388608, 8388607, 8388606, 8388605, 8388604};
    setup(MODE_SAW, MODE_SILENCE, 24'hFFFFFF, 24'h123456, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      get_frame(d, lat);
      checks++;
      if (ch_val(d, 0) !== exp0[i]) begin
        errors++; $display("FAIL wrap_saw[%0d] got=%0d want=%0d", i, ch_val(d, 0), exp0[i]);
      end
      checks++;
      if (ch_val(d, 1) !== 0) begin
        errors++; $display("FAIL wrap_silence[%0d] got=%0d want=0", i, ch_val(d, 1));
      end
    end
  endtask

  task automatic test_gain;
    logic [7:0] g [3];
    int exp_pos [3];
    int exp_neg [3];
    logic [CH*SW-1:0] d;
    int lat;
    g = '{8'd128, 8'd0, 8'd255};
`ifdef TONE_GENERATOR_GAIN_EN
    exp_pos = '{4194303, 0, 8355839};
    exp_neg = '{-4194304, 0, -8355840};
`else
    exp_pos = '{P, P, P};
    exp_neg = '{-P, -P, -P};
`endif
    for (int k = 0; k < 3; k++) begin
      setup(MODE_SINE, MODE_SILENCE, 24'h400000, 24'h0, g[k], g[k]);
      bus.out_ready = 1'b1;
      do_reset;
      for (int i = 0; i < 4; i++) begin
        get_frame(d, lat);
        if (i == 1) begin
          checks++;
          if (ch_val(d, 0) !== exp_pos[k]) begin
            errors++; $display("FAIL gain_pos[g=%0d] got=%0d want=%0d", g[k], ch_val(d, 0), exp_pos[k]);
          end
        end
        if (i == 3) begin
          checks++;
          if (ch_val(d, 0) !== exp_neg[k]) begin
            errors++; $display("FAIL gain_neg[g=%0d] got=%0d want=%0d", g[k], ch_val(d, 0), exp_neg[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [CH*SW-1:0] d;
    int lat;
    setup(MODE_SQUARE, MODE_SAW, 24'h400000, 24'h400000, 8'd255, 8'd255);
    bus.out_ready = 1'b1;
    do_reset;
    get_frame(d, lat);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_CALC) begin
      errors++; $display("FAIL mid_state got=%0d want=%0d", dbg_state, ST_CALC);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      errors++; $display("FAIL mid_reset valid=%b data=%h want valid=0 data=0", bus.out_valid, bus.out_data);
    end
    reset = 1'b0;
    get_frame(d, lat);
    checks++;
    if (lat !== CH + 2 || ch_val(d, 0) !== P || ch_val(d, 1) !== -8388608) begin
      errors++; $display("FAIL mid_first lat=%0d ch0=%0d ch1=%0d want lat=%0d ch0=%0d ch1=-8388608",
                         lat, ch_val(d, 0), ch_val(d, 1), CH + 2, P);
    end
  endtask

  initial begin
    test_reset;
    test_sine;
    test_square_saw;
    test_backpressure;
    test_wrap;
    test_gain;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
